// File: rtl/sram_controller_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
// Holds the controller state encoding, the default byte address of
// SRAM word 0 and the word/halfword widths used on both sides of it.
package sram_controller_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned HALF_W        = 16;
  localparam int unsigned DEF_BASE_ADDR = 1024;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } mem_state_t;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side memory request bus between the EX/MEM stage and the
// SRAM controller.
//   MEM_R_EN / MEM_W_EN : read / write request
//   ALUOut              : byte address
//   RMVal               : write data
//   ready               : high when no access is pending (pipeline may advance)
//   dataMemOut          : read data, held until the next read completes
// master = pipeline side, slave = controller side.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [WORD_W-1:0] ALUOut;
  logic [WORD_W-1:0] RMVal;
  logic              ready;
  logic [WORD_W-1:0] dataMemOut;

  modport master (
    output MEM_R_EN, MEM_W_EN, ALUOut, RMVal,
    input  ready, dataMemOut
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALUOut, RMVal,
    output ready, dataMemOut
  );

endinterface

// File: rtl/sram_controller.sv
// Multi-cycle data-memory responder: serves 32-bit pipeline reads and
// writes over a 16-bit external SRAM as two halfword accesses (low half
// first), each lasting WAIT_CYCLES clocks. `ready` is low while a request
// is in progress so the pipeline can freeze.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : pipeline request bus (slave side)
//   sram_addr  : SRAM halfword address {word_index, half}
//   sram_dq_o  : write data to SRAM
//   sram_dq_oe : data driver enable (tristate built at top level)
//   sram_dq_i  : read data from SRAM
//   sram_we_n  : active-low write strobe
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  sram_controller_if.slave    bus,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [HALF_W-1:0]   sram_dq_o,
  output logic                sram_dq_oe,
  input  logic [HALF_W-1:0]   sram_dq_i,
  output logic                sram_we_n
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  mem_state_t          state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                last;
  logic                req;
  logic [WORD_W-1:0]   offset;
  logic [SRAM_AW-2:0]  word_idx;
  logic [SRAM_AW-2:0]  word_lat;
  logic [WORD_W-1:0]   wdata_lat;
  logic [HALF_W-1:0]   cap_lo;
  logic [WORD_W-1:0]   rdata;
  logic                unused_bits;

  assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
  assign last     = (cnt == CW'(WAIT_CYCLES - 1));
  assign offset   = bus.ALUOut - WORD_W'(BASE_ADDR);
  // Byte lane bits and address bits above the SRAM are dropped: out-of-range
  // addresses wrap silently.
  assign word_idx = offset[SRAM_AW:2];
  assign unused_bits = ^{offset[WORD_W-1:SRAM_AW+1], offset[1:0]};

  assign bus.dataMemOut = rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    bus.ready  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ready = !req;
        if (bus.MEM_W_EN)      state_nxt = WR_LO;
        else if (bus.MEM_R_EN) state_nxt = RD_LO;
      end
      RD_LO: begin
        sram_addr = {word_lat, 1'b0};
        if (last) state_nxt = RD_HI;
      end
      RD_HI: begin
        sram_addr = {word_lat, 1'b1};
        if (last) state_nxt = DONE;
      end
      WR_LO: begin
        sram_addr  = {word_lat, 1'b0};
        sram_dq_o  = wdata_lat[HALF_W-1:0];
        sram_dq_oe = 1'b1;
        // Strobe released on the last cycle so the write ends on its rising
        // edge while address and data are still held.
        sram_we_n  = last;
        if (last) state_nxt = WR_HI;
      end
      WR_HI: begin
        sram_addr  = {word_lat, 1'b1};
        sram_dq_o  = wdata_lat[WORD_W-1:HALF_W];
        sram_dq_oe = 1'b1;
        sram_we_n  = last;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      word_lat  <= '0;
      wdata_lat <= '0;
      cap_lo    <= '0;
      rdata     <= '0;
    end else begin
      // Counter restarts on every state entry; it idles at zero in IDLE.
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + CW'(1);

      if (state == IDLE && req) begin
        word_lat <= word_idx;
        if (bus.MEM_W_EN) wdata_lat <= bus.RMVal;
      end

      if (state == RD_LO && last) cap_lo <= sram_dq_i;
      // The high half goes straight into the output together with the
      // captured low half, so data is valid in the DONE cycle.
      if (state == RD_HI && last) rdata <= {sram_dq_i, cap_lo};
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed vector table, hand
// sequences for reset-during-write and back-to-back reads, and random
// traffic against a word-level reference memory.
module tb_sram_controller;

  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;
  localparam int unsigned W    = 2;
  localparam int          LOWN = 2 * W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     sram_addr;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_i;
  logic              sram_we_n;

  int checks = 0;
  int errors = 0;

  sram_controller_if bus();

  sram_controller #(
    .BASE_ADDR  (BASE),
    .SRAM_AW    (AW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_i (sram_dq_i),
    .sram_we_n (sram_we_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: asynchronous read, write captured at the clock edge
  // while the strobe is low. Every write is logged as {addr, data}.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic [33:0] wlog [$];

  assign sram_dq_i = sram_mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      sram_mem[sram_addr] <= sram_dq_o;
      wlog.push_back({sram_addr, sram_dq_o});
    end
  end

  // Word-level reference memory.
  logic [31:0] ref_mem [int unsigned];

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o >> 2) % (1 << (AW - 1));
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One complete request; checks ready-low length, write halves on the SRAM
  // bus or read data, then data hold one cycle after return to IDLE.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
    int          low;
    bit          done;
    int unsigned i;
    logic [67:0] got;
    logic [31:0] exp;
    wlog.delete();
    @(posedge clk); #1;
    bus.MEM_R_EN = r; bus.MEM_W_EN = w; bus.ALUOut = a; bus.RMVal = d;
    low = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.ready) done = 1; else low++;
    end
    check("ready_low_cycles", low, LOWN);
    rd = bus.dataMemOut;
    i  = widx(a);
    exp = ref_rd(i);
    if (w) begin
      ref_mem[i] = d;
      got = (wlog.size() == 2) ? {wlog[0], wlog[1]} : '1;
      check("write_halves", got, {AW'(2*i), d[15:0], AW'(2*i+1), d[31:16]});
    end else begin
      check("read_data", rd, exp);
    end
    @(posedge clk); #1;
    bus.MEM_R_EN = 0; bus.MEM_W_EN = 0;
    @(negedge clk);
    check("ready_idle", bus.ready, 1'b1);
    if (!w) check("read_hold", bus.dataMemOut, exp);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] rd;
  logic [11:0] pat;

  initial begin
    for (int unsigned k = 0; k < (1 << AW); k++) sram_mem[k] = '0;
    rst = 1'b0;
    bus.MEM_R_EN = 0; bus.MEM_W_EN = 0; bus.ALUOut = '0; bus.RMVal = '0;

    // Reset state.
    #3;
    check("rst_ready",   bus.ready,      1'b1);
    check("rst_we_n",    sram_we_n,      1'b1);
    check("rst_oe",      sram_dq_oe,     1'b0);
    check("rst_addr",    sram_addr,      '0);
    check("rst_dq_o",    sram_dq_o,      '0);
    check("rst_dataout", bus.dataMemOut, '0);
    bus.MEM_R_EN = 1; #1;
    check("rst_ready_req", bus.ready, 1'b0);
    bus.MEM_R_EN = 0;
    #19 rst = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 32'd1032,   32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1032,   32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1040,   32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'd1040,   32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'd1035,   32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b1, 32'd525312, 32'h0BADC0DE, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'h0BADC0DE};
    vecs[7] = '{1'b0, 1'b1, 32'd1020,   32'h11112222, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'd525308, 32'h0,        32'h11112222};
    vecs[9] = '{1'b1, 1'b0, 32'd1036,   32'h0,        32'h0};
    foreach (vecs[k]) begin
      do_req(vecs[k].r, vecs[k].w, vecs[k].a, vecs[k].d, rd);
      if (!vecs[k].w) check($sformatf("vec%0d_data", k), rd, vecs[k].exp);
    end

    // Reset pulsed during the first WR_HI cycle: low half lands, high does not.
    do_req(1'b0, 1'b1, 32'd1048, 32'hAAAABBBB, rd);
    @(posedge clk); #1;
    bus.MEM_W_EN = 1; bus.ALUOut = 32'd1048; bus.RMVal = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wrhi_we_n", sram_we_n, 1'b0);
    check("wrhi_addr", sram_addr, AW'(13));
    check("wrhi_dq_o", sram_dq_o, 16'h1234);
    rst = 1'b0; #1;
    check("midrst_we_n",  sram_we_n,      1'b1);
    check("midrst_oe",    sram_dq_oe,     1'b0);
    check("midrst_addr",  sram_addr,      '0);
    check("midrst_dout",  bus.dataMemOut, '0);
    check("midrst_ready_req", bus.ready,  1'b0);
    bus.MEM_W_EN = 0; #1;
    check("midrst_ready", bus.ready, 1'b1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_lo_half", sram_mem[12], 16'h5678);
    check("midrst_hi_half", sram_mem[13], 16'hAAAA);
    ref_mem[6] = 32'hAAAA5678;
    do_req(1'b1, 1'b0, 32'd1048, 32'h0, rd);

    // Back-to-back reads at 1024 then 1028 with the request held high.
    @(posedge clk); #1;
    bus.MEM_R_EN = 1; bus.ALUOut = 32'd1024;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pat[k] = bus.ready;
      if (k == 5) begin
        check("b2b_data0", bus.dataMemOut, ref_rd(0));
        bus.ALUOut = 32'd1028;
      end
      if (k == 11) check("b2b_data1", bus.dataMemOut, ref_rd(1));
    end
    check("b2b_ready_pattern", pat, 12'h820);
    @(posedge clk); #1;
    bus.MEM_R_EN = 0;

    // Random traffic against the reference memory.
    for (int k = 0; k < 150; k++) begin
      int unsigned kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = BASE + $urandom_range(0, 31) * 4 + $urandom_range(0, 3)
          + $urandom_range(0, 1) * (1 << (AW + 1));
      do_req(kind != 1, kind != 0, a, $urandom, rd);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("rand_idle_ready", bus.ready, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
